// File: rtl/regfile.sv
// 32x32 register file with asynchronous reads and a 2-bit in-flight write scoreboard per register.
// Define REGFILE_BYPASS_EN for write-through forwarding and early release of the decode stall.
module regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   output logic [31:0] rdata1_o,
   output logic [31:0] rdata2_o,
   input  logic [4:0]  rd_i,
   input  logic [31:0] wdata_i,
   input  logic        regwrite_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        issue_we_i,
   output logic        hazard_o,
   output logic        issue_full_o
);

   logic [31:0]      r_regs [32];
   logic [31:0][1:0] r_pend;
   logic [31:0][1:0] w_pend_next;
   logic             w_wb;
   logic             w_base1;
   logic             w_base2;
   logic             w_busy1;
   logic             w_busy2;

   assign w_wb = regwrite_i && (rd_i != 5'd0);

   // Entry 0 is never written, so x0 stays zero without a special read path.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wb) begin
         r_regs[rd_i] <= wdata_i;
      end
   end

   assign w_pend_next[0] = 2'd0;

   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_pend
         logic w_inc;
         logic w_dec;
         assign w_inc = issue_we_i && (issue_rd_i == 5'(gi));
         assign w_dec = regwrite_i && (rd_i == 5'(gi));
         // Saturate at 3 and floor at 0; a simultaneous inc/dec cancels.
         assign w_pend_next[gi] =
            (w_inc && !w_dec && (r_pend[gi] != 2'd3)) ? r_pend[gi] + 2'd1 :
            (w_dec && !w_inc && (r_pend[gi] != 2'd0)) ? r_pend[gi] - 2'd1 :
                                                        r_pend[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_next;
      end
   end

   assign w_base1 = (rs1_i != 5'd0) && (r_pend[rs1_i] != 2'd0);
   assign w_base2 = (rs2_i != 5'd0) && (r_pend[rs2_i] != 2'd0);

`ifdef REGFILE_BYPASS_EN
   logic w_fwd1;
   logic w_fwd2;
   assign w_fwd1 = w_wb && (rd_i == rs1_i);
   assign w_fwd2 = w_wb && (rd_i == rs2_i);

   assign rdata1_o = (rs1_i == 5'd0) ? '0 : (w_fwd1 ? wdata_i : r_regs[rs1_i]);
   assign rdata2_o = (rs2_i == 5'd0) ? '0 : (w_fwd2 ? wdata_i : r_regs[rs2_i]);

   // The last outstanding write is landing now and is forwarded, so no stall is needed.
   assign w_busy1 = w_base1 && !(w_fwd1 && (r_pend[rs1_i] == 2'd1));
   assign w_busy2 = w_base2 && !(w_fwd2 && (r_pend[rs2_i] == 2'd1));
`else
   assign rdata1_o = (rs1_i == 5'd0) ? '0 : r_regs[rs1_i];
   assign rdata2_o = (rs2_i == 5'd0) ? '0 : r_regs[rs2_i];

   assign w_busy1 = w_base1;
   assign w_busy2 = w_base2;
`endif

   assign hazard_o     = w_busy1 || w_busy2;
   assign issue_full_o = (issue_rd_i != 5'd0) && (r_pend[issue_rd_i] == 2'd3);

endmodule
